// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the push-button debouncer array.
package debounce_pkg;

    // Per-channel debouncer states.
    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        DOWN,
        HELD,
        DISARM
    } deb_state_t;

    // Smallest counter width whose range strictly exceeds the largest count.
    function automatic int min_cnt_w(input int deb_cycles,
                                     input int hold_cycles,
                                     input int repeat_cycles);
        int m;
        m = deb_cycles;
        if (hold_cycles > m) m = hold_cycles;
        if (repeat_cycles > m) m = repeat_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_pb_chan.sv
// One push-button channel: 2-flop synchroniser, shared debounce/hold counter
// and the IDLE/ARMING/DOWN/HELD/DISARM state machine with registered outputs.
module debounce_pb_chan
    import debounce_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 26
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pb,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    // Terminal counts: the counter compares against these, one below the
    // number of cycles each phase lasts.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_repeat_nxt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pb;
            r_sync2 <= r_sync1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    // Next-state, counter and pulse decode; pulses default low so each lasts one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_level_nxt = 1'b0;
                if (r_sync2) begin
                    w_state_nxt = ARMING;
                    w_cnt_nxt   = '0;
                end
            end
            ARMING: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (!r_sync2) begin
                    w_state_nxt = DISARM;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    // Without auto-repeat the hold timer simply parks at its terminal count.
                    if (REPEAT_EN != 0) begin
                        w_state_nxt  = HELD;
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = DISARM;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DISARM: begin
                // A bounce back high cancels the release and restarts the hold timer.
                if (r_sync2) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/debounce_pb_array.sv
// Multi-channel push-button debouncer: N_CH independent channels sliced from
// the input/output buses, plus an elaboration check on the counter width.
module debounce_pb_array
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 26
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_pb,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_repeat
);

    // The counter must be able to reach the largest terminal count.
    if (CNT_W < min_cnt_w(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) begin : g_cnt_w_chk
        $error("debounce_pb_array: CNT_W=%0d too small for the configured cycle counts", CNT_W);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_pb_chan #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .CNT_W         (CNT_W)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_pb      (i_pb[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_debounce_pb_array.sv
// Bench for debounce_pb_array: run-length reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_debounce_pb_array;

    localparam int N_CH  = 2;
    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int REP   = 3;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] level, press, rel, rpt;
    logic [N_CH-1:0] level_nr, press_nr, rel_nr, rpt_nr;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit m_s1 [N_CH];
    bit m_s2 [N_CH];
    bit m_lvl[N_CH];
    int m_run[N_CH];
    int m_h  [N_CH];
    logic [N_CH-1:0] e_level = '0, e_press = '0, e_rel = '0, e_rpt = '0;

    always #5 clk = ~clk;

    debounce_pb_array #(
        .N_CH(N_CH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_pb(pb),
        .o_level(level), .o_press(press), .o_release(rel), .o_repeat(rpt)
    );

    debounce_pb_array #(
        .N_CH(N_CH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0), .CNT_W(CNT_W)
    ) dut_nr (
        .i_clk(clk), .i_reset(reset), .i_pb(pb),
        .o_level(level_nr), .o_press(press_nr), .o_release(rel_nr), .o_repeat(rpt_nr)
    );

    // Model: level flips after DEB+1 consecutive synchronised samples that
    // disagree with it; repeats fire HOLD samples after the (re)start of a
    // high run and every REP samples thereafter.
    always @(posedge clk) begin : model
        bit sp, lv, np, nr, nrp;
        int run, h;
        for (int c = 0; c < N_CH; c++) begin
            if (!reset) begin
                m_s1[c]  <= 1'b0;
                m_s2[c]  <= 1'b0;
                m_lvl[c] <= 1'b0;
                m_run[c] <= 0;
                m_h[c]   <= 0;
                e_level[c] <= 1'b0;
                e_press[c] <= 1'b0;
                e_rel[c]   <= 1'b0;
                e_rpt[c]   <= 1'b0;
            end else begin
                sp  = m_s2[c];
                lv  = m_lvl[c];
                run = m_run[c];
                h   = m_h[c];
                np  = 1'b0;
                nr  = 1'b0;
                nrp = 1'b0;
                if (sp != lv) run = run + 1;
                else run = 0;
                if (run == DEB + 1) begin
                    lv  = !lv;
                    run = 0;
                    h   = 0;
                    if (lv) np = 1'b1;
                    else nr = 1'b1;
                end else if (lv) begin
                    if (!sp) h = -1;
                    else if (h < 0) h = 0;
                    else begin
                        h = h + 1;
                        if (h >= HOLD && ((h - HOLD) % REP) == 0) nrp = 1'b1;
                    end
                end
                m_lvl[c] <= lv;
                m_run[c] <= run;
                m_h[c]   <= h;
                e_level[c] <= lv;
                e_press[c] <= np;
                e_rel[c]   <= nr;
                e_rpt[c]   <= nrp;
                m_s2[c] <= m_s1[c];
                m_s1[c] <= pb[c];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t actual lvl=%b prs=%b rel=%b rpt=%b required lvl=%b prs=%b rel=%b rpt=%b",
                         $time, level, press, rel, rpt, e_level, e_press, e_rel, e_rpt);
            end
            n_cmp++;
            if ({level_nr, press_nr, rel_nr, rpt_nr} !== {e_level, e_press, e_rel, 2'b00}) begin
                n_bad++;
                $display("FAIL model_cmp_norepeat t=%0t actual lvl=%b prs=%b rel=%b rpt=%b required lvl=%b prs=%b rel=%b rpt=00",
                         $time, level_nr, press_nr, rel_nr, rpt_nr, e_level, e_press, e_rel);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        pb    = '0;
        step(3);
        chk_en = 1'b1;
        chk("reset_outputs", {level, press, rel, rpt}, 32'h0);
        reset = 1'b1;
        step(3);

        // Clean press on channel 0, held into auto-repeat, then released
        pb[0] = 1'b1;
        step(6);  chk("s1_pre_press", {level[0], press[0]}, 32'h0);
        step(1);  chk("s1_press", {level, press}, 32'b0101);
                  chk("s1_model_press", e_press, 32'b01);
        step(1);  chk("s1_press_once", {level, press}, 32'b0100);
        step(9);  chk("s1_first_repeat", rpt, 32'b01);
        step(3);  chk("s1_second_repeat", rpt, 32'b01);
        pb[0] = 1'b0;
        step(6);  chk("s1_pre_release", {level[0], rel[0]}, 32'b10);
        step(1);  chk("s1_release", {level[0], rel[0]}, 32'b01);
        step(4);

        // Glitch of three cycles is rejected
        pb[0] = 1'b1; step(3); pb[0] = 1'b0;
        step(12); chk("s2_glitch_level", level[0], 32'h0);
                  chk("s2_model_level", e_level, 32'h0);

        // Release bounce: low 2, high 1, then low for good
        pb[0] = 1'b1;
        step(10); chk("s3_accepted", level[0], 32'h1);
        pb[0] = 1'b0; step(2); pb[0] = 1'b1; step(1); pb[0] = 1'b0;
        step(6);  chk("s3_no_release_yet", {level[0], rel[0]}, 32'b10);
        step(1);  chk("s3_release", {level[0], rel[0]}, 32'b01);
                  chk("s3_model_release", e_rel, 32'b01);
        step(4);

        // Auto-repeat on channel 1 over a 40-cycle hold
        pb[1] = 1'b1;
        step(7);  chk("s4_press", press, 32'b10);
        step(10); chk("s4_first_repeat", rpt, 32'b10);
                  chk("s4_norepeat_dut", rpt_nr, 32'h0);
        step(3);  chk("s4_second_repeat", rpt, 32'b10);
        step(20);
        pb[1] = 1'b0;
        step(7);  chk("s4_release", {level[1], rel[1]}, 32'b01);
        step(4);

        // Reset pulse while channel 0 is in auto-repeat
        pb[0] = 1'b1;
        step(20);
        reset = 1'b0;
        step(1);  chk("s5_reset_outputs", {level, press, rel, rpt}, 32'h0);
        reset = 1'b1;
        step(6);  chk("s5_pre_repress", press[0], 32'h0);
        step(1);  chk("s5_repress", {level[0], press[0]}, 32'b11);
        pb[0] = 1'b0;
        step(12);

        // Both channels together; channel 0 released while channel 1 repeats
        pb = 2'b11;
        step(7);  chk("s6_press_both", press, 32'b11);
        step(10); chk("s6_repeat_both", rpt, 32'b11);
        pb[0] = 1'b0;
        step(3);  chk("s6_ch1_repeat_a", rpt, 32'b10);
        step(3);  chk("s6_ch1_repeat_b", rpt, 32'b10);
        step(1);  chk("s6_ch0_release", {level, rel}, 32'b1001);
        step(2);  chk("s6_ch1_repeat_c", rpt, 32'b10);
        pb = 2'b00;
        step(12);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
